// File: rtl/bus_burst_slave_if.sv
// Burst bus between one master and the bus_burst_slave memory window.
// Signal directions in the modports are named from the slave's point of view.
interface bus_burst_slave_if;
   logic        beginTransactionIn;
   logic [31:0] addressDataIn;
   logic [3:0]  byteEnablesIn;
   logic [7:0]  burstSizeIn;
   logic        readNotWriteIn;
   logic        dataValidIn;
   logic        endTransactionIn;
   logic [31:0] addressDataOut;
   logic        dataValidOut;
   logic        endTransactionOut;
   logic        busyOut;
   logic        busErrorOut;

   modport slave (
      input  beginTransactionIn, addressDataIn, byteEnablesIn, burstSizeIn,
      input  readNotWriteIn, dataValidIn, endTransactionIn,
      output addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
   );

   modport master (
      output beginTransactionIn, addressDataIn, byteEnablesIn, burstSizeIn,
      output readNotWriteIn, dataValidIn, endTransactionIn,
      input  addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
   );
endinterface

// File: rtl/bus_burst_slave.sv
// Burst-capable memory slave with a 2^ADDR_WIDTH-word window at BASE_ADDRESS.
// Define BUS_BURST_SLAVE_ERROR_EN to reject bursts running past the window end.
module bus_burst_slave #(
   parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
   parameter int unsigned ADDR_WIDTH   = 9
) (
   input logic              clock,
   input logic              reset,
   bus_burst_slave_if.slave bus
);
   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   typedef enum logic [2:0] {
      StIdle, StReadSetup, StRead, StReadEnd, StWriteSetup, StWrite
   } state_e;

   state_e                  stateQ, stateD;
   logic [ADDR_WIDTH-1:0]   idxQ, idxD;
   logic [8:0]              cntQ, cntD;
   logic                    validQ, validD;
   logic                    endQ, endD;
   logic                    busyQ, busyD;
   logic                    errQ, errD;
   logic                    readEn, writeEn;
   logic                    selected, overflow;
   logic [ADDR_WIDTH-1:0]   beginIdx;
   logic [31:0]             ramData;
   logic [31:0]             mem [Depth];
   logic                    unusedAddrBits;

   assign beginIdx       = bus.addressDataIn[ADDR_WIDTH+1:2];
   assign selected       = bus.addressDataIn[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2];
   assign unusedAddrBits = ^bus.addressDataIn[1:0];

`ifdef BUS_BURST_SLAVE_ERROR_EN
   assign overflow = (32'(beginIdx) + 32'(bus.burstSizeIn)) > 32'(Depth - 1);
`else
   assign overflow = 1'b0;
`endif

   always_comb begin
      stateD  = stateQ;
      idxD    = idxQ;
      cntD    = cntQ;
      validD  = 1'b0;
      endD    = 1'b0;
      busyD   = 1'b0;
      errD    = 1'b0;
      readEn  = 1'b0;
      writeEn = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (bus.beginTransactionIn && selected) begin
               idxD = beginIdx;
               if (overflow) begin
                  errD = 1'b1;
                  endD = 1'b1;
               end else if (bus.readNotWriteIn) begin
                  stateD = StReadSetup;
                  cntD   = {1'b0, bus.burstSizeIn};
               end else begin
                  stateD = StWriteSetup;
                  cntD   = {1'b0, bus.burstSizeIn} + 9'd1;
                  busyD  = 1'b1;
               end
            end
         end
         // cntQ here counts words still to be issued after the first one
         StReadSetup: begin
            if (bus.endTransactionIn) begin
               stateD = StIdle;
            end else begin
               readEn = 1'b1;
               validD = 1'b1;
               idxD   = idxQ + 1'b1;
               stateD = (cntQ == 9'd0) ? StReadEnd : StRead;
            end
         end
         StRead: begin
            if (bus.endTransactionIn) begin
               stateD = StIdle;
            end else begin
               readEn = 1'b1;
               validD = 1'b1;
               idxD   = idxQ + 1'b1;
               cntD   = cntQ - 9'd1;
               if (cntQ == 9'd1) stateD = StReadEnd;
            end
         end
         StReadEnd: begin
            endD   = 1'b1;
            stateD = StIdle;
         end
         StWriteSetup: begin
            stateD = bus.endTransactionIn ? StIdle : StWrite;
         end
         // cntQ here counts words the burst may still accept; extras are dropped
         StWrite: begin
            if (bus.dataValidIn && cntQ != 9'd0) begin
               writeEn = 1'b1;
               idxD    = idxQ + 1'b1;
               cntD    = cntQ - 9'd1;
            end
            if (bus.endTransactionIn) stateD = StIdle;
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateQ <= StIdle;
         idxQ   <= '0;
         cntQ   <= '0;
         validQ <= 1'b0;
         endQ   <= 1'b0;
         busyQ  <= 1'b0;
         errQ   <= 1'b0;
      end else begin
         stateQ <= stateD;
         idxQ   <= idxD;
         cntQ   <= cntD;
         validQ <= validD;
         endQ   <= endD;
         busyQ  <= busyD;
         errQ   <= errD;
      end
   end

   // Memory is never reset so contents survive a mid-burst reset
   always_ff @(posedge clock) begin
      if (readEn) ramData <= mem[idxQ];
      if (writeEn) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.byteEnablesIn[b]) mem[idxQ][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
         end
      end
   end

   assign bus.addressDataOut    = validQ ? ramData : 32'd0;
   assign bus.dataValidOut      = validQ;
   assign bus.endTransactionOut = endQ;
   assign bus.busyOut           = busyQ;
   assign bus.busErrorOut       = errQ;
endmodule
